cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
Memory-side engine for the write-back data cache. It accepts a line miss from the cache. If the victim line is dirty, it first writes the line back to main memory as 4 single-word writes. It then reads the new 4-word line and returns it to the cache on fetch_data, qualified by a one-cycle fetch_enable pulse. It sits between the cache and the word-wide main memory port.

Parameters:
DATA_WIDTH, 32, word width in bits
BLOCK_SIZE, 4, words per cache line (beat count per burst)
ADDR_WIDTH, 32, byte-address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
miss_req  input  1  cache requests a line refill; sampled only in IDLE
miss_addr  input  ADDR_WIDTH  byte address of the missing access
wb_valid  input  1  victim line is dirty and must be written back; sampled with miss_req
wb_addr  input  ADDR_WIDTH  line-aligned victim address
wb_data  input  BLOCK_SIZE*DATA_WIDTH  victim line; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
busy  output  1  high whenever state != IDLE
mem_req  output  1  memory beat request
mem_we  output  1  1 = write beat, 0 = read beat
mem_addr  output  ADDR_WIDTH  word-aligned beat address
mem_wdata  output  DATA_WIDTH  write data for the beat
mem_rdata  input  DATA_WIDTH  read data; valid in the cycle mem_ack is high
mem_ack  input  1  beat completes on a cycle where mem_req && mem_ack
fetch_data  output  BLOCK_SIZE*DATA_WIDTH  refilled line; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
fetch_enable  output  1  one-cycle pulse: fetch_data is valid

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat=0. busy, mem_req, mem_we, fetch_enable are 0. mem_addr, mem_wdata and fetch_data are 0. Latched addresses and write data are cleared.
- FSM states: IDLE, WB, FILL, DONE.
- IDLE, on miss_req=1 at a clock edge:
  - Latch fill_base = {miss_addr[31:4], 4'b0}.
  - Latch wb_base = {wb_addr[31:4], 4'b0} and the full wb_data.
  - Set beat=0.
  - Go to WB if wb_valid=1, else go to FILL.
- WB:
  - mem_req=1, mem_we=1, mem_addr = wb_base + 4*beat, mem_wdata = latched word[beat].
  - On mem_ack: beat++. After the beat-3 ack, set beat=0 and go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = fill_base + 4*beat.
  - On mem_ack: capture mem_rdata into fetch_data[beat*32 +: 32] and increment beat.
  - After the beat-3 ack, go to DONE.
- DONE: fetch_enable=1 for exactly this cycle. mem_req=0. Go to IDLE next edge.
- mem_req, mem_we, mem_addr and mem_wdata are registered. They stay stable for the entire stall while mem_ack=0.
- mem_ack outside WB/FILL, or while mem_req=0, is ignored.
- No mem_req gap between consecutive beats, including across the WB→FILL transition.
- Latency, with a zero-wait memory (mem_ack tied high):
  - Clean miss: fetch_enable is high in the 5th cycle after the accepting edge.
  - Dirty miss: fetch_enable is high in the 9th cycle after the accepting edge.
  - Each stall cycle adds one cycle.
- miss_req while busy=1 is ignored. The cache must hold miss_req until it sees fetch_enable, then drop it.
  - A miss_req still high in the cycle after DONE starts a new transaction. This is intended only if the cache re-requests.
- fetch_data holds its value after DONE until the next FILL overwrites it beat by beat. Consumers must use it only when fetch_enable=1.
- Address arithmetic is ADDR_WIDTH-bit modulo; the offset never exceeds 12, so a line never crosses a 16-byte boundary.
- Reset mid-operation aborts immediately:
  - No partial-line guarantee in memory.
  - fetch_enable is never emitted for the aborted request.

Test Plan:
- Clean miss, zero-wait memory:
  - Stimulus: miss_addr=0x0000_1234, wb_valid=0; memory holds 0xA0/0xA1/0xA2/0xA3 at 0x1230/0x1234/0x1238/0x123C.
  - Required: 4 reads at those addresses in order; fetch_data=0x000000A3_000000A2_000000A1_000000A0; fetch_enable high exactly 1 cycle, 5 cycles after accept.
- Dirty miss:
  - Stimulus: wb_addr=0x0000_0010, wb_data words 0x11/0x22/0x33/0x44, miss_addr=0x0000_2000.
  - Required: writes 0x11@0x10, 0x22@0x14, 0x33@0x18, 0x44@0x1C, all before the first read of 0x2000; fetch_enable 9 cycles after accept; busy high throughout.
- Stalled memory:
  - Stimulus: mem_ack asserted only every 4th cycle of each beat during a dirty miss.
  - Required: mem_addr, mem_wdata and mem_we constant through each stall; same final memory contents and fetch_data as zero-wait; fetch_enable 33 cycles after accept.
- Busy collision:
  - Stimulus: a second miss_req with a different miss_addr during FILL beat 1.
  - Required: ignored; read addresses unchanged; exactly one fetch_enable.
- Reset mid-WB:
  - Stimulus: rst_n low during WB beat 2.
  - Required: mem_req, busy and fetch_enable drop to 0 asynchronously; after release, a new clean miss issues its first read at beat 0 of the new line.
- Top-of-map line:
  - Stimulus: miss_addr=0xFFFF_FFF8.
  - Required: reads at 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC; no wrap to 0x0.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//
// Memory-side refill engine for a write-back data cache. A line miss is
// accepted in IDLE. A dirty victim line is first written back as BLOCK_SIZE
// single-word write beats. The missing line is then read as BLOCK_SIZE
// single-word read beats and handed to the cache on fetch_data, qualified by
// a one-cycle fetch_enable pulse.
//
// Ports
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   miss_req      : refill request, sampled only while idle
//   miss_addr     : byte address of the missing access
//   wb_valid      : victim is dirty, sampled together with miss_req
//   wb_addr       : victim line address
//   wb_data       : victim line, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy          : engine is not idle
//   mem_req       : memory beat request (registered)
//   mem_we        : 1 = write beat, 0 = read beat (registered)
//   mem_addr      : word-aligned beat address (registered)
//   mem_wdata     : write data of the current beat (registered)
//   mem_rdata     : read data, valid while mem_ack is high
//   mem_ack       : beat completes on a cycle with mem_req && mem_ack
//   fetch_data    : refilled line, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fetch_enable  : one-cycle pulse marking fetch_data as valid
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int BLOCK_SIZE = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             miss_req,
   input  logic [ADDR_WIDTH-1:0]            miss_addr,
   input  logic                             wb_valid,
   input  logic [ADDR_WIDTH-1:0]            wb_addr,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] wb_data,
   output logic                             busy,
   output logic                             mem_req,
   output logic                             mem_we,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]            mem_wdata,
   input  logic [DATA_WIDTH-1:0]            mem_rdata,
   input  logic                             mem_ack,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] fetch_data,
   output logic                             fetch_enable
);

   localparam int LINE_W     = BLOCK_SIZE * DATA_WIDTH;
   localparam int WORD_BYTES = DATA_WIDTH / 8;
   localparam int BEAT_W     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int OFF_W      = $clog2(BLOCK_SIZE * WORD_BYTES);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_FILL = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                state_q;
   logic [BEAT_W-1:0]     beat_q;
   logic [ADDR_WIDTH-1:0] fill_base_q;
   logic [ADDR_WIDTH-1:0] wb_base_q;
   logic [LINE_W-1:0]     wb_line_q;
   logic [LINE_W-1:0]     fetch_data_q;
   logic                  busy_q;
   logic                  mem_req_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic                  fetch_en_q;

   logic [BEAT_W-1:0]     beat_d;
   logic                  last_beat_s;
   logic [ADDR_WIDTH-1:0] miss_line_s;
   logic [ADDR_WIDTH-1:0] wb_line_s;
   logic                  unused_s;

   // Address of word idx inside the line starting at base (modulo ADDR_WIDTH).
   function automatic logic [ADDR_WIDTH-1:0] beat_addr(
      input logic [ADDR_WIDTH-1:0] base,
      input logic [BEAT_W-1:0]     idx
   );
      beat_addr = base + (ADDR_WIDTH'(idx) * ADDR_WIDTH'(WORD_BYTES));
   endfunction

   // Word idx of a packed line; the compare loop keeps every slice constant.
   function automatic logic [DATA_WIDTH-1:0] line_word(
      input logic [LINE_W-1:0] line,
      input logic [BEAT_W-1:0] idx
   );
      line_word = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         if (idx == BEAT_W'(i)) begin
            line_word = line[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   endfunction

   assign beat_d      = beat_q + BEAT_W'(1);
   assign last_beat_s = (beat_q == LAST_BEAT);
   // Both bases are forced line-aligned, so offsets never carry out of the line.
   assign miss_line_s = {miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
   assign wb_line_s   = {wb_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
   // Byte-offset bits of the incoming addresses carry no information here.
   assign unused_s    = ^{miss_addr[OFF_W-1:0], wb_addr[OFF_W-1:0]};

   // Refill sequencer: state, beat counter, latched context and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         beat_q       <= {BEAT_W{1'b0}};
         fill_base_q  <= {ADDR_WIDTH{1'b0}};
         wb_base_q    <= {ADDR_WIDTH{1'b0}};
         wb_line_q    <= {LINE_W{1'b0}};
         fetch_data_q <= {LINE_W{1'b0}};
         busy_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {ADDR_WIDTH{1'b0}};
         mem_wdata_q  <= {DATA_WIDTH{1'b0}};
         fetch_en_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               fetch_en_q <= 1'b0;
               if (miss_req) begin
                  fill_base_q <= miss_line_s;
                  wb_base_q   <= wb_line_s;
                  wb_line_q   <= wb_data;
                  beat_q      <= {BEAT_W{1'b0}};
                  busy_q      <= 1'b1;
                  mem_req_q   <= 1'b1;
                  // The first beat is presented straight from the request
                  // inputs so it appears in the cycle after acceptance.
                  if (wb_valid) begin
                     state_q     <= ST_WB;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= wb_line_s;
                     mem_wdata_q <= line_word(wb_data, {BEAT_W{1'b0}});
                  end else begin
                     state_q     <= ST_FILL;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= miss_line_s;
                     mem_wdata_q <= {DATA_WIDTH{1'b0}};
                  end
               end else begin
                  busy_q    <= 1'b0;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
               end
            end

            ST_WB: begin
               if (mem_ack) begin
                  if (last_beat_s) begin
                     // Go straight into the first read so mem_req has no gap.
                     state_q     <= ST_FILL;
                     beat_q      <= {BEAT_W{1'b0}};
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= fill_base_q;
                     mem_wdata_q <= {DATA_WIDTH{1'b0}};
                  end else begin
                     beat_q      <= beat_d;
                     mem_addr_q  <= beat_addr(wb_base_q, beat_d);
                     mem_wdata_q <= line_word(wb_line_q, beat_d);
                  end
               end else begin
                  // Stall: every request field holds its value.
                  beat_q <= beat_q;
               end
            end

            ST_FILL: begin
               if (mem_ack) begin
                  for (int i = 0; i < BLOCK_SIZE; i++) begin
                     if (beat_q == BEAT_W'(i)) begin
                        fetch_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                     end
                  end
                  if (last_beat_s) begin
                     state_q    <= ST_DONE;
                     beat_q     <= {BEAT_W{1'b0}};
                     mem_req_q  <= 1'b0;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= {ADDR_WIDTH{1'b0}};
                     fetch_en_q <= 1'b1;
                  end else begin
                     beat_q     <= beat_d;
                     mem_addr_q <= beat_addr(fill_base_q, beat_d);
                  end
               end else begin
                  beat_q <= beat_q;
               end
            end

            ST_DONE: begin
               // miss_req is not looked at here; the cache drops it on fetch_enable.
               state_q    <= ST_IDLE;
               busy_q     <= 1'b0;
               fetch_en_q <= 1'b0;
            end

            default: begin
               state_q    <= ST_IDLE;
               beat_q     <= {BEAT_W{1'b0}};
               busy_q     <= 1'b0;
               mem_req_q  <= 1'b0;
               mem_we_q   <= 1'b0;
               fetch_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign fetch_data   = fetch_data_q;
   assign fetch_enable = fetch_en_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
//
// Directed and randomized refill transactions. The bench plays both the cache
// and a word-addressed main memory; expected beat sequences, line contents and
// latency are derived from the line-refill rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;

   logic         clk;
   logic         rst_n;
   logic         miss_req;
   logic [31:0]  miss_addr;
   logic         wb_valid;
   logic [31:0]  wb_addr;
   logic [127:0] wb_data;
   logic         busy;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;
   logic         mem_ack;
   logic [127:0] fetch_data;
   logic         fetch_enable;

   int checks;
   int errors;

   logic [31:0] mem [logic [31:0]];

   cache_refill_ctrl #(
      .DATA_WIDTH (32),
      .BLOCK_SIZE (4),
      .ADDR_WIDTH (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .miss_req     (miss_req),
      .miss_addr    (miss_addr),
      .wb_valid     (wb_valid),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .busy         (busy),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .fetch_data   (fetch_data),
      .fetch_enable (fetch_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      else return a ^ 32'h5EED_0000;
   endfunction

   // One cache miss, from request to the idle cycle after fetch_enable.
   // mode: 0 zero-wait, 1 ack on every 4th cycle of a beat, 2 random ack.
   task automatic run_miss(input logic [31:0] maddr, input logic wbv, input logic [31:0] wba,
                           input logic [127:0] wbd, input int mode, input int abort_beat,
                           input int collide_beat, output int fe_cycle);
      logic [31:0]  fill_b, wb_b, a, w;
      logic [31:0]  exp_addr[$];
      logic         exp_we[$];
      logic [31:0]  exp_wd[$];
      logic [127:0] exp_line;
      logic [31:0]  prev_addr, prev_wd;
      logic         prev_we, prev_stall, ack;
      int           nbeats, done_beats, stalls, gaps, fe_count, wait_cnt;

      fill_b = {maddr[31:4], 4'h0};
      wb_b   = {wba[31:4], 4'h0};
      nbeats = wbv ? 8 : 4;
      if (wbv) begin
         for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(wb_b + 32'(4 * i));
            exp_we.push_back(1'b1);
            exp_wd.push_back(wbd[i*32 +: 32]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         a = fill_b + 32'(4 * i);
         exp_addr.push_back(a);
         exp_we.push_back(1'b0);
         exp_wd.push_back(32'h0);
         w = mem_read(a);
         if (wbv) begin
            for (int j = 0; j < 4; j++) begin
               if (a == wb_b + 32'(4 * j)) w = wbd[j*32 +: 32];
            end
         end
         exp_line[i*32 +: 32] = w;
      end

      @(negedge clk);
      miss_req  = 1'b1;
      miss_addr = maddr;
      wb_valid  = wbv;
      wb_addr   = wba;
      wb_data   = wbd;
      mem_ack   = 1'b0;

      fe_cycle   = -1;
      done_beats = 0;
      stalls     = 0;
      gaps       = 0;
      fe_count   = 0;
      wait_cnt   = 0;
      prev_stall = 1'b0;
      prev_addr  = 32'h0;
      prev_wd    = 32'h0;
      prev_we    = 1'b0;

      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (k == 1) begin
            // The line context must have been latched at acceptance.
            wb_valid = 1'($urandom_range(0, 1));
            wb_addr  = $urandom;
            wb_data  = {$urandom, $urandom, $urandom, $urandom};
         end
         if (fe_cycle > 0) begin
            check("busy_after_done", busy, 1'b0);
            check("fe_one_cycle", fetch_enable, 1'b0);
            mem_ack = 1'b0;
            break;
         end
         if (abort_beat >= 0 && done_beats == abort_beat && mem_req) begin
            mem_ack = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("abort_mem_req", mem_req, 1'b0);
            check("abort_busy", busy, 1'b0);
            check("abort_fe", fetch_enable, 1'b0);
            miss_req = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         check("busy_during", busy, 1'b1);
         if (prev_stall) begin
            check("stall_addr", mem_addr, prev_addr);
            check("stall_we", mem_we, prev_we);
            check("stall_wdata", mem_wdata, prev_wd);
         end
         if (collide_beat >= 0 && mem_req && !mem_we && done_beats == nbeats - 4 + collide_beat) begin
            miss_req  = 1'b1;
            miss_addr = maddr ^ 32'h0100_0000;
         end
         if (fetch_enable) begin
            fe_count++;
            if (fe_cycle < 0) fe_cycle = k;
            check("req_in_done", mem_req, 1'b0);
            miss_req = 1'b0;
         end else if (!mem_req) begin
            gaps++;
         end
         case (mode)
            0:       ack = 1'b1;
            1:       ack = (wait_cnt == 3);
            default: ack = 1'($urandom_range(0, 1));
         endcase
         if (mem_req) begin
            if (ack) wait_cnt = 0;
            else wait_cnt++;
         end
         if (mem_req && ack) begin
            if (done_beats < exp_addr.size()) begin
               check("beat_addr", mem_addr, exp_addr[done_beats]);
               check("beat_we", mem_we, exp_we[done_beats]);
               if (exp_we[done_beats]) check("beat_wdata", mem_wdata, exp_wd[done_beats]);
            end else begin
               check("extra_beat", 1'b1, 1'b0);
            end
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata = mem_read(mem_addr);
            done_beats++;
         end else begin
            mem_rdata = $urandom;
         end
         if (mem_req && !ack) stalls++;
         prev_stall = mem_req && !ack;
         prev_addr  = mem_addr;
         prev_we    = mem_we;
         prev_wd    = mem_wdata;
         mem_ack    = ack;
      end

      check("latency", fe_cycle, nbeats + stalls + 1);
      check("beat_count", done_beats, nbeats);
      check("req_gap", gaps, 0);
      check("fe_count", fe_count, 1);
      check("fetch_data", fetch_data, exp_line);
   endtask

   initial begin : stimulus
      int           fe;
      logic [127:0] dirty_line;
      logic [127:0] rnd_data;
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      miss_req  = 1'b0;
      miss_addr = 32'h0;
      wb_valid  = 1'b0;
      wb_addr   = 32'h0;
      wb_data   = 128'h0;
      mem_rdata = 32'h0;
      mem_ack   = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_fe", fetch_enable, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_fetch_data", fetch_data, 128'h0);
      rst_n = 1'b1;

      // Clean miss, zero-wait
      mem[32'h1230] = 32'hA0;
      mem[32'h1234] = 32'hA1;
      mem[32'h1238] = 32'hA2;
      mem[32'h123C] = 32'hA3;
      run_miss(32'h0000_1234, 1'b0, 32'h0, 128'h0, 0, -1, -1, fe);
      check("clean_latency", fe, 5);
      check("clean_line", fetch_data, 128'h000000A3_000000A2_000000A1_000000A0);

      // Dirty miss, zero-wait
      run_miss(32'h0000_2000, 1'b1, 32'h0000_0010,
               128'h00000044_00000033_00000022_00000011, 0, -1, -1, fe);
      check("dirty_latency", fe, 9);
      check("dirty_mem10", mem[32'h10], 32'h11);
      check("dirty_mem14", mem[32'h14], 32'h22);
      check("dirty_mem18", mem[32'h18], 32'h33);
      check("dirty_mem1c", mem[32'h1C], 32'h44);
      dirty_line = fetch_data;

      // Same dirty miss against a memory acking every 4th cycle
      for (int i = 0; i < 4; i++) mem[32'h10 + 32'(4 * i)] = 32'h0;
      run_miss(32'h0000_2000, 1'b1, 32'h0000_0010,
               128'h00000044_00000033_00000022_00000011, 1, -1, -1, fe);
      check("stall_latency", fe, 33);
      check("stall_mem10", mem[32'h10], 32'h11);
      check("stall_mem1c", mem[32'h1C], 32'h44);
      check("stall_line", fetch_data, dirty_line);

      // Second miss_req with a different address during FILL beat 1
      run_miss(32'h0000_3008, 1'b0, 32'h0, 128'h0, 0, -1, 1, fe);
      check("collide_latency", fe, 5);

      // Reset during WB beat 2, then a fresh clean miss
      run_miss(32'h0000_4000, 1'b1, 32'h0000_5000,
               128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, 0, 2, -1, fe);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_abort_fe", fetch_enable, 1'b0);
         check("post_abort_busy", busy, 1'b0);
         check("post_abort_req", mem_req, 1'b0);
      end
      run_miss(32'h0000_6004, 1'b0, 32'h0, 128'h0, 0, -1, -1, fe);
      check("after_abort_latency", fe, 5);

      // Top-of-map line
      run_miss(32'hFFFF_FFF8, 1'b0, 32'h0, 128'h0, 0, -1, -1, fe);
      check("top_latency", fe, 5);
      check("top_word3", fetch_data[127:96], mem_read(32'hFFFF_FFFC));

      // Randomized misses
      for (int n = 0; n < 24; n++) begin
         rnd_data = {$urandom, $urandom, $urandom, $urandom};
         run_miss($urandom, 1'($urandom_range(0, 1)), $urandom, rnd_data,
                  int'($urandom_range(0, 2)), -1, -1, fe);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
